// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared op encodings, FSM states and gate truth function
package gate_chk_pkg;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Expected gate output for the selected function
  function automatic logic gate_eval(input logic [1:0] op, input logic a, input logic b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

endpackage

// File: rtl/gate_chk_cnt.sv
// rtl/gate_chk_cnt.sv - saturating counter with synchronous clear
module gate_chk_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gate_resp_checker.sv
// rtl/gate_resp_checker.sv - gate response checker; optional coverage gating via GATE_CHK_COVERAGE_EN
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int VECTORS = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_a,
  input  logic             s_b,
  input  logic             s_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec,
  output logic [3:0]       cov_mask
);

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] idx;
  logic             accept;
  logic             last_accept;
  logic             run_clr;
  logic             mismatch;
  logic             cov_full;

  // Ready depends on state alone so there is no path from s_valid
  assign s_ready     = (state == ST_RUN);
  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign accept      = s_valid && s_ready;
  assign last_accept = accept && (idx == CNT_W'(VECTORS - 1));
  // A start is honoured only outside RUN; it latches op and clears the run record
  assign run_clr     = start && (state != ST_RUN);
  assign mismatch    = accept && (s_y != gate_eval(op_q, s_a, s_b));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a final accept wins over any start on the same edge
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_accept) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Op latch, vector index and first-mismatch capture
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q           <= OP_AND;
      idx            <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
    end else if (run_clr) begin
      op_q           <= op;
      idx            <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
    end else if (accept) begin
      idx <= idx + CNT_W'(1);
      if (mismatch && !first_fail_vld) begin
        first_fail_vld <= 1'b1;
        first_fail_idx <= idx;
        first_fail_vec <= {s_a, s_b, s_y};
      end
    end
  end

  gate_chk_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (accept && !mismatch),
    .cnt (pass_cnt)
  );

  gate_chk_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (mismatch),
    .cnt (fail_cnt)
  );

`ifdef GATE_CHK_COVERAGE_EN
  // Record which {a,b} combinations were exercised this run
  always_ff @(posedge clk) begin
    if (rst || run_clr) begin
      cov_mask <= 4'h0;
    end else if (accept) begin
      cov_mask[{s_a, s_b}] <= 1'b1;
    end
  end
  assign cov_full = (cov_mask == 4'hF);
`else
  assign cov_mask = 4'h0;
  assign cov_full = 1'b1;
`endif

  assign pass = done && (fail_cnt == '0) && cov_full;

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb/tb_gate_resp_checker.sv - randomized self-checking bench for gate_resp_checker
module tb_gate_resp_checker;

  localparam int VECTORS = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic             s_valid;
  logic             s_ready;
  logic             s_a, s_b, s_y;
  logic             busy, done, pass;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic             first_fail_vld;
  logic [CNT_W-1:0] first_fail_idx;
  logic [2:0]       first_fail_vec;
  logic [3:0]       cov_mask;

  int total = 0;
  int bad   = 0;

  logic [2:0] vq[$];
  int         exp_pc, exp_fc, exp_ffi;
  logic       exp_ffv, exp_pass;
  logic [2:0] exp_ffvec;
  logic [3:0] exp_cov;
  logic       obs_ready_ok, obs_done_last, obs_busy_last, obs_ready_last;

  gate_resp_checker #(.VECTORS(VECTORS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_y(s_y),
    .busy(busy), .done(done), .pass(pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
    .first_fail_vec(first_fail_vec), .cov_mask(cov_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: truth tables indexed by {a,b}, scored over the whole vector list
  task automatic model_calc(input logic [1:0] op_i);
    logic [3:0] tt;
    logic [3:0] cov;
    case (op_i)
      2'd0:    tt = 4'b1000;
      2'd1:    tt = 4'b1110;
      2'd2:    tt = 4'b0110;
      default: tt = 4'b0111;
    endcase
    exp_pc = 0; exp_fc = 0; exp_ffv = 1'b0; exp_ffi = 0; exp_ffvec = 3'b000; cov = 4'h0;
    for (int i = 0; i < vq.size(); i++) begin
      cov[vq[i][2:1]] = 1'b1;
      if (tt[vq[i][2:1]] == vq[i][0]) exp_pc++;
      else begin
        exp_fc++;
        if (!exp_ffv) begin exp_ffv = 1'b1; exp_ffi = i; exp_ffvec = vq[i]; end
      end
    end
`ifdef GATE_CHK_COVERAGE_EN
    exp_cov  = cov;
    exp_pass = (exp_fc == 0) && (cov == 4'hF);
`else
    exp_cov  = 4'h0;
    exp_pass = (exp_fc == 0);
`endif
  endtask

  function automatic logic [2:0] good_vec(input logic [1:0] op_i, input logic a, input logic b);
    int s;
    s = int'(a) + int'(b);
    case (op_i)
      2'd0:    return {a, b, s == 2};
      2'd1:    return {a, b, s >= 1};
      2'd2:    return {a, b, s == 1};
      default: return {a, b, s != 2};
    endcase
  endfunction

  // Issue start then play vq; gap<0 picks random gaps; records handshake observations
  task automatic drive_run(input logic [1:0] op_i, input int gap, input bit start_during);
    int g;
    start = 1'b1; op = op_i;
    step();
    start = 1'b0; op = 2'($urandom);
    obs_ready_ok = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      if (s_ready !== 1'b1 || busy !== 1'b1) obs_ready_ok = 1'b0;
      s_valid = 1'b1;
      {s_a, s_b, s_y} = vq[i];
      start = start_during && (i > 0);
      step();
      s_valid = 1'b0; start = 1'b0;
      {s_a, s_b, s_y} = 3'($urandom);
      if (i == vq.size() - 1) begin
        obs_done_last = done; obs_busy_last = busy; obs_ready_last = s_ready;
      end else begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int k = 0; k < g; k++) begin
          if (s_ready !== 1'b1) obs_ready_ok = 1'b0;
          step();
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0; s_valid = 1'b0; s_a = 1'b0; s_b = 1'b0; s_y = 1'b0;
    step(); step();
    rst = 1'b0;
    total++;
    if ({s_ready, busy, done, pass, first_fail_vld} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {s_ready, busy, done, pass, first_fail_vld});
    end
    total++;
    if (pass_cnt !== 0 || fail_cnt !== 0 || first_fail_idx !== 0 || first_fail_vec !== 0 || cov_mask !== 0) begin
      bad++; $display("FAIL reset_values: pc=%0d fc=%0d ffi=%0d ffvec=%b cov=%b want all 0",
                      pass_cnt, fail_cnt, first_fail_idx, first_fail_vec, cov_mask);
    end
    step();
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %b want 0", s_ready); end
  endtask

  task automatic test_or_pass();
    vq = '{3'b000, 3'b011, 3'b101, 3'b111};
    model_calc(2'd1);
    drive_run(2'd1, 0, 1'b0);
    total++;
    if ({obs_done_last, obs_busy_last, obs_ready_last, obs_ready_ok} !== 4'b1001) begin
      bad++; $display("FAIL or_handshake: got %b want 1001", {obs_done_last, obs_busy_last, obs_ready_last, obs_ready_ok});
    end
    total++;
    if (pass_cnt !== 4 || fail_cnt !== 0 || first_fail_vld !== 1'b0) begin
      bad++; $display("FAIL or_counts: pc=%0d fc=%0d ffv=%b want 4 0 0", pass_cnt, fail_cnt, first_fail_vld);
    end
    total++;
    if (pass !== exp_pass || cov_mask !== exp_cov) begin
      bad++; $display("FAIL or_verdict: pass=%b cov=%b want %b %b", pass, cov_mask, exp_pass, exp_cov);
    end
  endtask

  task automatic test_and_fail();
    vq = '{3'b000, 3'b011, 3'b100, 3'b110};
    model_calc(2'd0);
    drive_run(2'd0, 0, 1'b0);
    total++;
    if (fail_cnt !== 2 || pass_cnt !== 2) begin
      bad++; $display("FAIL and_counts: pc=%0d fc=%0d want 2 2", pass_cnt, fail_cnt);
    end
    total++;
    if (first_fail_vld !== 1'b1 || first_fail_idx !== 1 || first_fail_vec !== 3'b011) begin
      bad++; $display("FAIL and_first_fail: vld=%b idx=%0d vec=%b want 1 1 011", first_fail_vld, first_fail_idx, first_fail_vec);
    end
    total++;
    if (pass !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL and_verdict: pass=%b done=%b want 0 1", pass, done);
    end
  endtask

  task automatic test_xor_gaps();
    logic ready_seen;
    vq = '{3'b000, 3'b011, 3'b101, 3'b110};
    model_calc(2'd2);
    drive_run(2'd2, 2, 1'b0);
    total++;
    if ({obs_done_last, obs_busy_last, obs_ready_last, obs_ready_ok} !== 4'b1001) begin
      bad++; $display("FAIL xor_gap_handshake: got %b want 1001", {obs_done_last, obs_busy_last, obs_ready_last, obs_ready_ok});
    end
    // Keep offering vectors in DONE; none may be taken
    ready_seen = 1'b0;
    s_valid = 1'b1; s_a = 1'b1; s_b = 1'b1; s_y = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (s_ready !== 1'b0) ready_seen = 1'b1;
      step();
    end
    s_valid = 1'b0;
    total++;
    if (ready_seen !== 1'b0 || pass_cnt + fail_cnt !== 4 || pass_cnt !== 16'(exp_pc)) begin
      bad++; $display("FAIL xor_done_hold: ready=%b pc=%0d fc=%0d want 0 %0d %0d", ready_seen, pass_cnt, fail_cnt, exp_pc, exp_fc);
    end
    total++;
    if (pass !== exp_pass || done !== 1'b1) begin
      bad++; $display("FAIL xor_verdict: pass=%b done=%b want %b 1", pass, done, exp_pass);
    end
  endtask

  task automatic test_rst_abort();
    start = 1'b1; op = 2'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; {s_a, s_b, s_y} = 3'b010;
      step();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({s_ready, busy, done, pass, first_fail_vld} !== 5'b0 || pass_cnt !== 0 || fail_cnt !== 0
        || first_fail_idx !== 0 || first_fail_vec !== 0 || cov_mask !== 0) begin
      bad++; $display("FAIL rst_abort: flags=%b pc=%0d fc=%0d want all 0",
                      {s_ready, busy, done, pass, first_fail_vld}, pass_cnt, fail_cnt);
    end
    vq = '{good_vec(2'd3, 0, 0), good_vec(2'd3, 0, 1), good_vec(2'd3, 1, 0), good_vec(2'd3, 1, 1)};
    model_calc(2'd3);
    drive_run(2'd3, 0, 1'b0);
    total++;
    if (pass !== 1'b1 || pass_cnt !== 4 || fail_cnt !== 0) begin
      bad++; $display("FAIL nand_after_rst: pass=%b pc=%0d fc=%0d want 1 4 0", pass, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_all_zero_cov();
    vq = '{3'b000, 3'b000, 3'b000, 3'b000};
    model_calc(2'd1);
    drive_run(2'd1, 0, 1'b0);
    total++;
    if (fail_cnt !== 0 || cov_mask !== exp_cov || pass !== exp_pass) begin
      bad++; $display("FAIL zero_cov: fc=%0d cov=%b pass=%b want 0 %b %b", fail_cnt, cov_mask, pass, exp_cov, exp_pass);
    end
  endtask

  task automatic test_start_ignored();
    vq = '{3'b001, 3'b011, 3'b100, 3'b110};
    model_calc(2'd0);
    drive_run(2'd0, 0, 1'b1);
    total++;
    if (done !== 1'b1 || pass_cnt !== 16'(exp_pc) || fail_cnt !== 16'(exp_fc) || first_fail_idx !== 16'(exp_ffi)) begin
      bad++; $display("FAIL start_in_run: done=%b pc=%0d fc=%0d ffi=%0d want 1 %0d %0d %0d",
                      done, pass_cnt, fail_cnt, first_fail_idx, exp_pc, exp_fc, exp_ffi);
    end
    start = 1'b1; op = 2'd2;
    step();
    start = 1'b0;
    total++;
    if ({busy, done, s_ready, first_fail_vld} !== 4'b1010 || pass_cnt !== 0 || fail_cnt !== 0) begin
      bad++; $display("FAIL restart_clear: flags=%b pc=%0d fc=%0d want 1010 0 0", {busy, done, s_ready, first_fail_vld}, pass_cnt, fail_cnt);
    end
    // drive_run re-issues start while in RUN; op XOR latched above must remain
    vq = '{3'b000, 3'b011, 3'b101, 3'b111};
    model_calc(2'd2);
    drive_run(2'd0, 0, 1'b0);
    total++;
    if (fail_cnt !== 16'(exp_fc) || first_fail_idx !== 16'(exp_ffi) || first_fail_vec !== exp_ffvec || pass !== exp_pass) begin
      bad++; $display("FAIL restart_run: fc=%0d ffi=%0d vec=%b pass=%b want %0d %0d %b %b",
                      fail_cnt, first_fail_idx, first_fail_vec, pass, exp_fc, exp_ffi, exp_ffvec, exp_pass);
    end
  endtask

  task automatic test_random();
    logic [1:0] rop;
    logic [2:0] v;
    for (int r = 0; r < 25; r++) begin
      rop = 2'($urandom);
      vq = {};
      for (int i = 0; i < VECTORS; i++) begin
        v = good_vec(rop, 1'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) v[0] = ~v[0];
        vq.push_back(v);
      end
      model_calc(rop);
      drive_run(rop, -1, 1'($urandom));
      total++;
      if (pass_cnt !== 16'(exp_pc) || fail_cnt !== 16'(exp_fc) || pass !== exp_pass || cov_mask !== exp_cov) begin
        bad++; $display("FAIL rand_%0d_counts: pc=%0d fc=%0d pass=%b cov=%b want %0d %0d %b %b",
                        r, pass_cnt, fail_cnt, pass, cov_mask, exp_pc, exp_fc, exp_pass, exp_cov);
      end
      total++;
      if (first_fail_vld !== exp_ffv || first_fail_idx !== 16'(exp_ffi) || first_fail_vec !== exp_ffvec
          || obs_done_last !== 1'b1 || obs_ready_ok !== 1'b1) begin
        bad++; $display("FAIL rand_%0d_first: vld=%b idx=%0d vec=%b done=%b rdy=%b want %b %0d %b 1 1",
                        r, first_fail_vld, first_fail_idx, first_fail_vec, obs_done_last, obs_ready_ok,
                        exp_ffv, exp_ffi, exp_ffvec);
      end
      if ($urandom_range(0, 3) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_or_pass();
    test_and_fail();
    test_xor_gaps();
    test_rst_abort();
    test_all_zero_cov();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
